// File: rtl/bst_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NREQ requesters.
// Optional grant lock for atomic read-modify-write: define BST_ARB_LOCK_EN.
module bst_ram_arbiter #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16,
    parameter int NREQ   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_busy,
    input  logic [NREQ-1:0]          req_wreq,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          resp_valid,
    output logic [DWIDTH-1:0]        resp_data,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic                     ram_wreq,
    output logic [DWIDTH-1:0]        ram_wdata,
    input  logic [DWIDTH-1:0]        ram_rdata
);

    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned N  = NREQ;

    typedef enum logic [1:0] {IDLE, ACC, RDAT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_wreq_q, ram_wreq_d;
    logic [DWIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic [NREQ-1:0]     resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0]   resp_data_q, resp_data_d;
    logic                lock_q, lock_d;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic                found;

    // Search upward from last+1 with wrap; fall back to last+1 when nothing is valid.
    always_comb begin
        found = 1'b0;
        win   = IW'((32'(last_q) + 32'd1) % N);
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_q) + k) % N);
            if (!found && req_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
`ifdef BST_ARB_LOCK_EN
        if (lock_q) begin
            win = gnt_q;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        ram_addr_d   = ram_addr_q;
        ram_wreq_d   = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        lock_d       = lock_q;
        req_busy     = '1;
        case (state_q)
            IDLE: begin
                req_busy = ~(NREQ'(1) << win);
                if (req_valid[win]) begin
                    ram_addr_d  = req_addr[win*AWIDTH +: AWIDTH];
                    ram_wdata_d = req_wdata[win*DWIDTH +: DWIDTH];
                    ram_wreq_d  = req_wreq[win];
                    gnt_d       = win;
                    last_d      = win;
`ifdef BST_ARB_LOCK_EN
                    lock_d      = req_lock[win];
`endif
                    state_d     = ACC;
                end
            end
            // ram_wreq_q is high in ACC exactly when the access is a write
            ACC: begin
                state_d = ram_wreq_q ? IDLE : RDAT;
            end
            RDAT: begin
                resp_data_d  = ram_rdata;
                resp_valid_d = NREQ'(1) << gnt_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IW'(N - 1);
            gnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_wreq_q   <= 1'b0;
            ram_wdata_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_wreq_q   <= ram_wreq_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            lock_q       <= lock_d;
        end
    end

`ifndef BST_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    assign ram_addr   = ram_addr_q;
    assign ram_wreq   = ram_wreq_q;
    assign ram_wdata  = ram_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_bst_ram_arbiter.sv
// Scoreboard bench for bst_ram_arbiter (NREQ=2): stimulus pushes expected
// read responses, independent monitors log grants and check responses.
module tb_bst_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_busy, req_wreq, req_lock, resp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] resp_data, ram_addr, ram_wdata, ram_rdata;
    logic        ram_wreq;

    bst_ram_arbiter #(.AWIDTH(16), .DWIDTH(16), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_busy(req_busy), .req_wreq(req_wreq),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .ram_addr(ram_addr), .ram_wreq(ram_wreq), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255] = '{1: 16'hA001, 2: 16'hB002, default: 16'h0000};
    always @(posedge clk) begin
        if (ram_wreq) mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[7:0]];
    end

    typedef struct { int idx; logic [15:0] data; } resp_t;
    resp_t exp_q[$];
    int    rd_cyc_q[$];
    int    gnt_log[$];
    int    gnt_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Grant monitor: inputs are stable at negedge, so this is what the next edge accepts.
    logic [1:0] acc;
    int         g;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cyc_q.delete();
        end else begin
            acc = req_valid & ~req_busy;
            if (acc != 2'b00) begin
                chk("single_grant", 32'($countones(acc)), 32'd1);
                g = acc[1] ? 1 : 0;
                gnt_log.push_back(g);
                gnt_cyc.push_back(cyc);
                if (!req_wreq[g]) rd_cyc_q.push_back(cyc);
            end
        end
    end

    resp_t      e;
    int         c;
    logic [1:0] expv;
    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_resp resp_valid=%b resp_data=%h (t=%0t)", resp_valid, resp_data, $time);
            end else begin
                e = exp_q.pop_front();
                expv = 2'b01 << e.idx;
                chk("resp_valid", 32'(resp_valid), 32'(expv));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                if (rd_cyc_q.size() > 0) begin
                    c = rd_cyc_q.pop_front();
                    chk("resp_latency", 32'(cyc - c), 32'd3);
                end else begin
                    checks++; failures++;
                    $display("FAIL resp_without_read_accept resp_valid=%b (t=%0t)", resp_valid, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input int i, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic lk);
        bit ok = 1'b0;
        req_valid[i] = 1'b1; req_wreq[i] = wr; req_lock[i] = lk;
        req_addr[i*16 +: 16] = a; req_wdata[i*16 +: 16] = d;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (!req_busy[i]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout req=%0d actual=busy required=accepted", i);
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_grants(input int n);
        for (int k = 0; k < 60 && gnt_log.size() < n; k++) @(negedge clk);
        chk("grant_count", 32'(gnt_log.size() >= n), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_wreq = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wreq", 32'(ram_wreq), 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_busy", 32'(req_busy), 32'h2);

        // Write 0xBEEF to 0x0010, then a second write held back-to-back
        tick();
        req_valid = 2'b01; req_wreq = 2'b01; req_addr[15:0] = 16'h0010; req_wdata[15:0] = 16'hBEEF;
        @(negedge clk);
        chk("wr_busy_c0", 32'(req_busy), 32'h2);
        tick();
        req_addr[15:0] = 16'h0011; req_wdata[15:0] = 16'h1234;
        @(negedge clk);
        chk("wr_ram_wreq_c1", 32'(ram_wreq), 32'h1);
        chk("wr_ram_addr_c1", 32'(ram_addr), 32'h0010);
        chk("wr_ram_wdata_c1", 32'(ram_wdata), 32'hBEEF);
        chk("wr_busy_c1", 32'(req_busy), 32'h3);
        @(negedge clk);
        chk("wr_ram_wreq_c2", 32'(ram_wreq), 32'h0);
        chk("wr_busy_c2", 32'(req_busy), 32'h2);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("wr2_ram_wreq", 32'(ram_wreq), 32'h1);
        chk("wr2_ram_addr", 32'(ram_addr), 32'h0011);
        chk("wr2_ram_wdata", 32'(ram_wdata), 32'h1234);
        chk("wr2_ram_addr_hold", 32'(ram_addr), 32'h0011);

        // Requester 1 reads back 0x0010
        tick();
        exp_q.push_back('{1, 16'hBEEF});
        issue(1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        drain();
        chk("idle_addr_hold", 32'(ram_addr), 32'h0010);

        // Both requesters reading continuously: grants alternate 0,1,0,1
        tick();
        gnt_log.delete(); gnt_cyc.delete();
        req_wreq = 2'b00; req_addr = {16'h0002, 16'h0001}; req_valid = 2'b11;
        exp_q.push_back('{0, 16'hA001}); exp_q.push_back('{1, 16'hB002});
        exp_q.push_back('{0, 16'hA001}); exp_q.push_back('{1, 16'hB002});
        wait_grants(4);
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(gnt_log[k]), 32'(k % 2));
            if (k > 0) chk($sformatf("rr_spacing%0d", k), 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd3);
        end
        drain();

        // Lock scenario: requester 1 read(lock=1) then write(lock=0), requester 0 always valid
        tick();
        exp_q.push_back('{0, 16'hA001});
        issue(0, 1'b0, 16'h0001, 16'h0000, 1'b0);
        drain();
        tick();
        gnt_log.delete(); gnt_cyc.delete();
        req_wreq = 2'b00; req_lock = 2'b10; req_addr = {16'h0010, 16'h0001}; req_valid = 2'b11;
        exp_q.push_back('{1, 16'hBEEF}); exp_q.push_back('{0, 16'hA001});
        for (int k = 0; k < 60; k++) begin
            int n;
            @(negedge clk);
            n = gnt_log.size();
            tick();
            if (n >= 1) begin
                req_wreq[1] = 1'b1; req_lock[1] = 1'b0;
                req_addr[31:16] = 16'h0012; req_wdata[31:16] = 16'h5555;
            end
            if (n >= 3) begin
                req_valid = 2'b00;
                break;
            end
        end
        chk("lock_grant_count", 32'(gnt_log.size()), 32'd3);
`ifdef BST_ARB_LOCK_EN
        if (gnt_log.size() >= 3) begin
            chk("lock_grant0", 32'(gnt_log[0]), 32'd1);
            chk("lock_grant1", 32'(gnt_log[1]), 32'd1);
            chk("lock_grant2", 32'(gnt_log[2]), 32'd0);
        end
`else
        if (gnt_log.size() >= 3) begin
            chk("nolock_grant0", 32'(gnt_log[0]), 32'd1);
            chk("nolock_grant1", 32'(gnt_log[1]), 32'd0);
            chk("nolock_grant2", 32'(gnt_log[2]), 32'd1);
        end
`endif
        drain();
        req_wreq = 2'b00; req_lock = 2'b00;

        // Reset during ACC of a read: access dropped, no response afterwards
        tick();
        issue(0, 1'b0, 16'h0002, 16'h0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ram_wreq", 32'(ram_wreq), 32'h0);
        chk("arst_resp_valid", 32'(resp_valid), 32'h0);
        chk("arst_ram_addr", 32'(ram_addr), 32'h0);
        chk("arst_busy", 32'(req_busy), 32'h2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        tick();
        gnt_log.delete(); gnt_cyc.delete();
        req_addr = {16'h0002, 16'h0001}; req_valid = 2'b11;
        exp_q.push_back('{0, 16'hA001});
        wait_grants(1);
        tick();
        req_valid = 2'b00;
        if (gnt_log.size() >= 1) chk("post_rst_grant", 32'(gnt_log[0]), 32'd0);
        drain();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
